// File: rtl/seg_scan_driver_pkg.sv
// Shared types, FSM encodings and the active-low hex glyph table for the segment scan driver.
package seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'h7F;

   localparam logic [1:0] ST_BLANK = 2'd0;
   localparam logic [1:0] ST_ON    = 2'd1;
   localparam logic [1:0] ST_OFF   = 2'd2;

   // Bit 0 is segment a, bit 6 is segment g; a 0 lights the segment.
   function automatic seg_t hex_to_seg_n(input logic [3:0] nib);
      seg_t g;
      case (nib)
         4'h0:    g = 7'h40;
         4'h1:    g = 7'h79;
         4'h2:    g = 7'h24;
         4'h3:    g = 7'h30;
         4'h4:    g = 7'h19;
         4'h5:    g = 7'h12;
         4'h6:    g = 7'h02;
         4'h7:    g = 7'h78;
         4'h8:    g = 7'h00;
         4'h9:    g = 7'h10;
         4'hA:    g = 7'h08;
         4'hB:    g = 7'h03;
         4'hC:    g = 7'h46;
         4'hD:    g = 7'h21;
         4'hE:    g = 7'h06;
         default: g = 7'h0E;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle: digit data and controls in, anode/segment drive and scan status out.
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 2,
   parameter int BRIGHT_W   = 3
) ();

   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    lz_suppress;
   logic [BRIGHT_W-1:0]     brightness;
   logic [NUM_DIGITS-1:0]   control;
   seg_pkg::seg_t           seg;
   logic [IDX_W-1:0]        digit_idx;
   logic                    frame_start;

   modport master (
      output digits, blank_mask, lz_suppress, brightness,
      input  control, seg, digit_idx, frame_start
   );

   modport slave (
      input  digits, blank_mask, lz_suppress, brightness,
      output control, seg, digit_idx, frame_start
   );

endinterface

// File: rtl/seg_scan_driver_scan_timer.sv
// Slot phase counter and digit index; digit_idx/frame_start are registered to line up
// with the registered anode/segment outputs of the top level.
module scan_timer #(
   parameter  int NUM_DIGITS  = 2,
   parameter  int SLOT_CYCLES = 100000,
   localparam int PW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1,
   localparam int IW = $clog2(NUM_DIGITS)
) (
   input  logic          clk,
   input  logic          reset,
   output logic [PW-1:0] phase,
   output logic [IW-1:0] cur_idx,
   output logic [IW-1:0] digit_idx,
   output logic          frame_start
);

   localparam logic [PW-1:0] LAST_PHASE = PW'(SLOT_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase       <= '0;
         cur_idx     <= '0;
         digit_idx   <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= (phase == '0) && (cur_idx == '0);
         digit_idx   <= cur_idx;
         if (phase == LAST_PHASE) begin
            phase   <= '0;
            cur_idx <= (cur_idx == LAST_IDX) ? '0 : cur_idx + IW'(1);
         end else begin
            phase <= phase + PW'(1);
         end
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with blanking interval, brightness
// PWM, per-digit masking and leading-zero suppression. All pin outputs are registered.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 2,
   parameter int SLOT_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 2000,
   parameter int BRIGHT_W     = 3
) (
   input logic              clk,
   input logic              reset,
   seg_scan_driver_if.slave disp
);

   localparam int PW     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int IW     = $clog2(NUM_DIGITS);
   localparam int WINDOW = SLOT_CYCLES - BLANK_CYCLES;
   localparam int PRODW  = PW + BRIGHT_W + 1;
   localparam int OLW    = PW + 1;
   localparam int EW     = PW + 2;

   logic [PW-1:0]         phase;
   logic [IW-1:0]         cur_idx;

   logic [3:0]            live_nib,    slot_nib,    eff_nib;
   logic                  live_dark,   slot_dark,   eff_dark;
   logic [OLW-1:0]        live_on_len, slot_on_len, eff_on_len;
   logic                  hi_zero;
   logic [PRODW-1:0]      prod;
   logic [EW-1:0]         on_end;

   logic [1:0]            state, base, state_n;
   logic [NUM_DIGITS-1:0] control_q;
   seg_t                  seg_q;

   scan_timer #(
      .NUM_DIGITS (NUM_DIGITS),
      .SLOT_CYCLES(SLOT_CYCLES)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .phase      (phase),
      .cur_idx    (cur_idx),
      .digit_idx  (disp.digit_idx),
      .frame_start(disp.frame_start)
   );

   // Snapshot candidates taken from the live inputs; only used on the phase-0 cycle.
   always_comb begin
      live_nib = disp.digits[4*cur_idx +: 4];
      hi_zero  = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (i >= 32'(cur_idx) && disp.digits[4*i +: 4] != 4'h0) hi_zero = 1'b0;
      end
      live_dark   = disp.blank_mask[cur_idx] |
                    (disp.lz_suppress && (cur_idx != '0) && hi_zero);
      prod        = PRODW'(WINDOW) * (PRODW'(disp.brightness) + PRODW'(1));
      live_on_len = OLW'(prod >> BRIGHT_W);
   end

   // On phase 0 the slot registers are still loading, so bypass them with the live values.
   always_comb begin
      eff_nib    = (phase == '0) ? live_nib    : slot_nib;
      eff_dark   = (phase == '0) ? live_dark   : slot_dark;
      eff_on_len = (phase == '0) ? live_on_len : slot_on_len;
      on_end     = EW'(BLANK_CYCLES) + EW'(eff_on_len);
   end

   // state is the phase of the cycle now showing on the pins; state_n is the next one.
   always_comb begin
      base    = (phase == '0) ? ST_BLANK : state;
      state_n = base;
      case (base)
         ST_BLANK: begin
            if (EW'(phase) == EW'(BLANK_CYCLES))
               state_n = (eff_on_len == '0) ? ST_OFF : ST_ON;
         end
         ST_ON: begin
            if (EW'(phase) == on_end) state_n = ST_OFF;
         end
         default: state_n = base;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_BLANK;
         slot_nib    <= '0;
         slot_dark   <= 1'b0;
         slot_on_len <= '0;
         control_q   <= '1;
         seg_q       <= SEG_OFF;
      end else begin
         state <= state_n;
         if (phase == '0) begin
            slot_nib    <= live_nib;
            slot_dark   <= live_dark;
            slot_on_len <= live_on_len;
         end
         if (state_n == ST_ON && !eff_dark) begin
            control_q <= ~(NUM_DIGITS'(1) << cur_idx);
            seg_q     <= hex_to_seg_n(eff_nib);
         end else begin
            control_q <= '1;
            seg_q     <= SEG_OFF;
         end
      end
   end

   assign disp.control = control_q;
   assign disp.seg     = seg_q;

endmodule
